// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences the shared multiply/divide units and owns the architectural HI/LO registers.
// Requests are accepted in IDLE only; each run lasts a fixed cycle budget, then HI/LO commit and done pulses.
module muldiv_ctrl #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_req,
    input  logic             div_req,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_lo,
    input  logic [WIDTH-1:0] div_hi,
    input  logic [WIDTH-1:0] div_lo,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             mult_start,
    output logic             div_start,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    typedef enum logic [1:0] {IDLE, M_RUN, D_RUN, COMMIT} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] op_a_nx, op_b_nx, hi_nx, lo_nx;
    logic             mult_start_nx, div_start_nx, div_zero_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            HI         <= '0;
            LO         <= '0;
            mult_start <= 1'b0;
            div_start  <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            op_a       <= op_a_nx;
            op_b       <= op_b_nx;
            HI         <= hi_nx;
            LO         <= lo_nx;
            mult_start <= mult_start_nx;
            div_start  <= div_start_nx;
            div_zero   <= div_zero_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        op_a_nx       = op_a;
        op_b_nx       = op_b;
        hi_nx         = HI;
        lo_nx         = LO;
        mult_start_nx = 1'b0;
        div_start_nx  = 1'b0;
        div_zero_nx   = 1'b0;
        case (state)
            IDLE: begin
                // Lower-priority requests in the same cycle are dropped, not queued.
                if (mult_req) begin
                    op_a_nx       = a_in;
                    op_b_nx       = b_in;
                    cnt_nx        = CNT_W'(MULT_CYCLES);
                    mult_start_nx = 1'b1;
                    state_nx      = M_RUN;
                end else if (div_req) begin
                    if (b_in == '0) begin
                        div_zero_nx = 1'b1;
                        state_nx    = COMMIT;
                    end else begin
                        op_a_nx      = a_in;
                        op_b_nx      = b_in;
                        cnt_nx       = CNT_W'(DIV_CYCLES);
                        div_start_nx = 1'b1;
                        state_nx     = D_RUN;
                    end
                end else begin
                    if (mthi) hi_nx = a_in;
                    if (mtlo) lo_nx = a_in;
                end
            end
            M_RUN, D_RUN: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    hi_nx    = (state == M_RUN) ? mult_hi : div_hi;
                    lo_nx    = (state == M_RUN) ? mult_lo : div_lo;
                    state_nx = COMMIT;
                end
            end
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == M_RUN) || (state == D_RUN);
    assign done = (state == COMMIT);
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and random requests against an arithmetic model of HI/LO behaviour.
// The multiply/divide units are modelled combinationally from the latched operands.
module tb_muldiv_ctrl;
    localparam int W = 32;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         mult_req = 1'b0, div_req = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [W-1:0] a_in = '0, b_in = '0;
    logic [W-1:0] mult_hi, mult_lo, div_hi, div_lo;
    logic [W-1:0] op_a, op_b, HI, LO;
    logic         mult_start, div_start, busy, done, div_zero;

    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] exp_hi = '0, exp_lo = '0;

    muldiv_ctrl dut (
        .clk(clk), .reset(reset), .mult_req(mult_req), .div_req(div_req),
        .mthi(mthi), .mtlo(mtlo), .a_in(a_in), .b_in(b_in),
        .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
        .op_a(op_a), .op_b(op_b), .mult_start(mult_start), .div_start(div_start),
        .HI(HI), .LO(LO), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    assign {mult_hi, mult_lo} = 64'(op_a) * 64'(op_b);
    assign div_lo = (op_b == '0) ? '0 : op_a / op_b;
    assign div_hi = (op_b == '0) ? '0 : op_a % op_b;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request cycle and follow it to completion, checking against the model.
    task automatic run_op(input bit m, input bit d, input bit h, input bit l,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0]  prod;
        logic [W-1:0] old_hi, old_lo;
        int           n, nb, ms, ds;
        old_hi = exp_hi;
        old_lo = exp_lo;
        mult_req = m; div_req = d; mthi = h; mtlo = l; a_in = a; b_in = b;
        tick();
        mult_req = 0; div_req = 0; mthi = 0; mtlo = 0;
        a_in = $urandom; b_in = $urandom;
        if (m || (d && b != 0)) begin
            prod = 64'(a) * 64'(b);
            exp_hi = m ? prod[63:32] : a % b;
            exp_lo = m ? prod[31:0]  : a / b;
            chk("start_mult", mult_start, m);
            chk("start_div", div_start, !m);
            chk("hi_untouched", HI, old_hi);
            chk("lo_untouched", LO, old_lo);
            n = 0; nb = 0; ms = 0; ds = 0;
            while (!done && n < 200) begin
                nb += int'(busy);
                ms += int'(mult_start);
                ds += int'(div_start);
                tick();
                n++;
            end
            if (n >= 200) begin
                chk("timeout", 1, 0);
                return;
            end
            chk("busy_cycles", nb, N);
            chk("mult_start_cnt", ms, m ? 1 : 0);
            chk("div_start_cnt", ds, m ? 0 : 1);
            chk("hi_result", HI, exp_hi);
            chk("lo_result", LO, exp_lo);
            chk("div_zero_clr", div_zero, 0);
            chk("op_a_held", op_a, a);
            chk("op_b_held", op_b, b);
            tick();
            chk("done_pulse", done, 0);
        end else if (d) begin
            chk("dz_done", done, 1);
            chk("dz_flag", div_zero, 1);
            chk("dz_no_start", div_start, 0);
            chk("dz_busy", busy, 0);
            chk("dz_hi", HI, exp_hi);
            chk("dz_lo", LO, exp_lo);
            tick();
            chk("dz_done_pulse", done, 0);
            chk("dz_flag_pulse", div_zero, 0);
        end else begin
            if (h) exp_hi = a;
            if (l) exp_lo = a;
            chk("mt_hi", HI, exp_hi);
            chk("mt_lo", LO, exp_lo);
            chk("mt_no_done", done, 0);
            chk("mt_no_busy", busy, 0);
        end
    endtask

    initial begin
        int saw_done;
        repeat (2) tick();
        reset = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_idle", {busy, done, mult_start, div_start}, 0);
        end
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);

        run_op(1, 0, 0, 0, 7, 6);
        chk("mult_42_lo", LO, 42);
        chk("mult_42_hi", HI, 0);
        run_op(0, 1, 0, 0, 100, 7);
        chk("div_lo_14", LO, 14);
        chk("div_hi_2", HI, 2);
        run_op(0, 0, 1, 1, 32'hAAAA_AAAA, 0);
        run_op(0, 1, 0, 0, 5, 0);
        run_op(1, 1, 1, 0, 32'h0001_0000, 32'h0001_0003);
        run_op(0, 0, 1, 1, 32'h1234, 0);

        // Reset in the middle of a multiply aborts it.
        mult_req = 1; a_in = 9; b_in = 9;
        tick();
        mult_req = 0;
        repeat (9) tick();
        #2 reset = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_hi", HI, 0);
        chk("abort_lo", LO, 0);
        exp_hi = 0; exp_lo = 0;
        @(posedge clk); #1 reset = 1;
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            saw_done += int'(done);
        end
        chk("abort_no_done", saw_done, 0);
        chk("abort_busy_after", busy, 0);
        run_op(1, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]   r;
            logic [W-1:0] a, b;
            r = 4'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
            run_op(r[0], r[1], r[2], r[3], a, b);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
